// File: rtl/keccak_unpadder.sv
// rtl/keccak_unpadder.sv - strips Keccak 0x06..0x80 byte padding from whole rate blocks
module keccak_unpadder #(
  parameter int RATE_WORDS = 34
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] in,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  output logic        out_last,
  output logic [1:0]  out_byte_num,
  input  logic        out_ready,
  output logic        pad_err
);

  localparam int PW = $clog2(RATE_WORDS);
  localparam logic [PW-1:0] LAST_PTR = PW'(RATE_WORDS - 1);

  typedef enum logic [1:0] {FILL, SCAN, DRAIN} state_t;

  state_t         state, state_d;
  logic [31:0]    mem [RATE_WORDS];
  logic [PW-1:0]  wptr, rptr, sptr;
  logic [PW+1:0]  msg_len;
  logic           final_q;
  logic           pad_err_d;

  logic [31:0]    scan_word;
  logic           scan_found, scan_err;
  logic [1:0]     scan_byte;
  logic [PW-1:0]  last_idx;
  logic           drain_last;
  logic [31:0]    drain_word;

  // Block buffer: written only while filling, never reset
  always_ff @(posedge clk) begin
    if (state == FILL && in_valid) mem[wptr] <= in;
  end

  // Backward pad scan of one word: bytes 3..0, byte 0 being the MSB byte
  always_comb begin
    scan_found = 1'b0;
    scan_err   = 1'b0;
    scan_byte  = 2'd0;
    scan_word  = mem[sptr];
    for (int k = 3; k >= 0; k--) begin
      if (!scan_found && !scan_err) begin
        if (sptr == LAST_PTR && k == 3) begin
          if (scan_word[8*(3-k) +: 8] == 8'h86) begin
            scan_found = 1'b1;
            scan_byte  = 2'(k);
          end else if (scan_word[8*(3-k) +: 8] != 8'h80) begin
            scan_err = 1'b1;
          end
        end else if (scan_word[8*(3-k) +: 8] == 8'h06) begin
          scan_found = 1'b1;
          scan_byte  = 2'(k);
        end else if (scan_word[8*(3-k) +: 8] != 8'h00) begin
          scan_err = 1'b1;
        end
      end
    end
    if (!scan_found && !scan_err && sptr == '0) scan_err = 1'b1;
  end

  // Drain word: mask bytes at or past the message end on the final block
  always_comb begin
    last_idx   = final_q ? msg_len[PW+1:2] : LAST_PTR;
    drain_last = (rptr == last_idx);
    drain_word = mem[rptr];
    for (int k = 0; k < 4; k++) begin
      if (final_q && {rptr, 2'(k)} >= msg_len) drain_word[8*(3-k) +: 8] = 8'h00;
    end
    in_ready     = (state == FILL);
    out_valid    = (state == DRAIN);
    out          = out_valid ? drain_word : 32'd0;
    out_last     = out_valid && final_q && drain_last;
    out_byte_num = out_last ? msg_len[1:0] : 2'd0;
  end

  // Next-state and error pulse decisions
  always_comb begin
    state_d   = state;
    pad_err_d = 1'b0;
    case (state)
      FILL: begin
        if (in_valid) begin
          if (wptr == LAST_PTR) state_d = in_last ? SCAN : DRAIN;
          else if (in_last)     pad_err_d = 1'b1;
        end
      end
      SCAN: begin
        if (scan_err) begin
          pad_err_d = 1'b1;
          state_d   = FILL;
        end else if (scan_found) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_ready && drain_last) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FILL;
    else       state <= state_d;
  end

  // Pointers, final flag, message length and error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr    <= '0;
      rptr    <= '0;
      sptr    <= '0;
      msg_len <= '0;
      final_q <= 1'b0;
      pad_err <= 1'b0;
    end else begin
      pad_err <= pad_err_d;
      case (state)
        FILL: begin
          if (in_valid) begin
            wptr <= (wptr == LAST_PTR || in_last) ? '0 : wptr + 1'b1;
            if (wptr == LAST_PTR) begin
              final_q <= in_last;
              sptr    <= LAST_PTR;
              rptr    <= '0;
            end
          end
        end
        SCAN: begin
          if (scan_found)     msg_len <= {sptr, scan_byte};
          else if (!scan_err) sptr <= sptr - 1'b1;
          if (scan_err)       final_q <= 1'b0;
        end
        DRAIN: begin
          if (out_ready) begin
            if (drain_last) begin
              rptr    <= '0;
              final_q <= 1'b0;
            end else begin
              rptr <= rptr + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_keccak_unpadder.sv
// tb/tb_keccak_unpadder.sv - scoreboard bench for keccak_unpadder with RATE_WORDS=4
module tb_keccak_unpadder;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] din = 32'd0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [31:0] dout;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_byte_num;
  logic        out_ready = 1'b1;
  logic        pad_err;

  int checks = 0;
  int errors = 0;
  int pad_cnt = 0;
  logic [34:0] q [$];

  logic        prev_stall = 1'b0;
  logic [34:0] prev_out = '0;

  keccak_unpadder #(.RATE_WORDS(4)) dut (
    .clk(clk), .reset(reset),
    .in(din), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out(dout), .out_valid(out_valid), .out_last(out_last),
    .out_byte_num(out_byte_num), .out_ready(out_ready), .pad_err(pad_err)
  );

  always #5 clk = ~clk;

  // Output monitor: scoreboard pop, stall stability, pad_err rules
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall && out_valid) begin
        checks++;
        if ({dout, out_last, out_byte_num} !== prev_out) begin
          errors++;
          $display("FAIL stall_stable got=%h want=%h", {dout, out_last, out_byte_num}, prev_out);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output got=%h", {dout, out_last, out_byte_num});
        end else if ({dout, out_last, out_byte_num} !== q[0]) begin
          errors++;
          $display("FAIL out_word got=%h/%b/%0d want=%h/%b/%0d", dout, out_last, out_byte_num,
                   q[0][34:3], q[0][2], q[0][1:0]);
          void'(q.pop_front());
        end else begin
          void'(q.pop_front());
        end
      end
      if (pad_err) begin
        pad_cnt++;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
          errors++;
          $display("FAIL pad_err_ctx out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {dout, out_last, out_byte_num};
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic send_word(input logic [31:0] w, input logic l);
    int n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (in_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL send_timeout in_ready=%b want 1", in_ready);
    end
    din = w;
    in_valid = 1'b1;
    in_last = l;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic send_block(input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2, input logic [31:0] w3, input logic l);
    send_word(w0, 1'b0);
    send_word(w1, 1'b0);
    send_word(w2, 1'b0);
    send_word(w3, l);
  endtask

  task automatic expect_word(input logic [31:0] w, input logic l, input logic [1:0] bn);
    q.push_back({w, l, bn});
  endtask

  task automatic wait_idle(input string name, input int exp_pads, input int pads_before);
    int n = 0;
    while ((q.size() != 0 || in_ready !== 1'b1) && n < 500) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_idle pending=%0d in_ready=%b want 0/1", name, q.size(), in_ready);
    end
    checks++;
    if (pad_cnt - pads_before != exp_pads) begin
      errors++;
      $display("FAIL %s_pad_err pulses=%0d want %0d", name, pad_cnt - pads_before, exp_pads);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, out_valid, out_last, out_byte_num, dout, pad_err} !== {1'b1, 1'b0, 1'b0, 2'd0, 32'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state rdy=%b v=%b l=%b bn=%0d out=%h err=%b want 1/0/0/0/0/0",
               in_ready, out_valid, out_last, out_byte_num, dout, pad_err);
    end
  endtask

  task automatic test_five_byte();
    int p = pad_cnt;
    expect_word(32'h90ABCDEF, 1'b0, 2'd0);
    expect_word(32'h90000000, 1'b1, 2'd1);
    send_block(32'h90ABCDEF, 32'h90060000, 32'h00000000, 32'h00000080, 1'b1);
    wait_idle("five_byte", 0, p);
  endtask

  task automatic test_pad_86();
    int p = pad_cnt;
    expect_word(32'h11111111, 1'b0, 2'd0);
    expect_word(32'h22222222, 1'b0, 2'd0);
    expect_word(32'h33333333, 1'b0, 2'd0);
    expect_word(32'hAABBCC00, 1'b1, 2'd3);
    send_block(32'h11111111, 32'h22222222, 32'h33333333, 32'hAABBCC86, 1'b1);
    wait_idle("pad_86", 0, p);
  endtask

  task automatic test_word_aligned();
    int p = pad_cnt;
    expect_word(32'h12345678, 1'b0, 2'd0);
    expect_word(32'h00000000, 1'b1, 2'd0);
    send_block(32'h12345678, 32'h06000000, 32'h00000000, 32'h00000080, 1'b1);
    wait_idle("word_aligned", 0, p);
  endtask

  task automatic test_back_to_back();
    int p = pad_cnt;
    expect_word(32'hA0A0A0A0, 1'b0, 2'd0);
    expect_word(32'hA1A1A1A1, 1'b0, 2'd0);
    expect_word(32'hA2A2A2A2, 1'b0, 2'd0);
    expect_word(32'hA3A3A3A3, 1'b0, 2'd0);
    expect_word(32'h00000000, 1'b1, 2'd0);
    send_block(32'hA0A0A0A0, 32'hA1A1A1A1, 32'hA2A2A2A2, 32'hA3A3A3A3, 1'b0);
    send_block(32'h06000000, 32'h00000000, 32'h00000000, 32'h00000080, 1'b1);
    wait_idle("multi_block", 0, p);
  endtask

  task automatic test_errors();
    int p = pad_cnt;
    send_block(32'h06000000, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1);
    wait_idle("err_last_byte", 1, p);
    p = pad_cnt;
    send_block(32'h06000000, 32'h00010000, 32'h00000000, 32'h00000080, 1'b1);
    wait_idle("err_stray", 1, p);
    p = pad_cnt;
    send_word(32'h12345678, 1'b0);
    send_word(32'h06000080, 1'b1);
    wait_idle("err_short", 1, p);
  endtask

  task automatic test_stall_toggle();
    int n = 0;
    int p = pad_cnt;
    out_ready = 1'b0;
    expect_word(32'h11111111, 1'b0, 2'd0);
    expect_word(32'h22222222, 1'b0, 2'd0);
    expect_word(32'h33333333, 1'b0, 2'd0);
    expect_word(32'hAABBCC00, 1'b1, 2'd3);
    send_block(32'h11111111, 32'h22222222, 32'h33333333, 32'hAABBCC86, 1'b1);
    while (q.size() != 0 && n < 200) begin
      @(posedge clk);
      #1;
      out_ready = ~out_ready;
      n++;
    end
    out_ready = 1'b1;
    wait_idle("stall_toggle", 0, p);
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    out_ready = 1'b0;
    send_block(32'h90ABCDEF, 32'h90060000, 32'h00000000, 32'h00000080, 1'b1);
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL drain_start out_valid=%b want 1", out_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_drain out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
    end
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    test_word_aligned();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_five_byte();
    test_pad_86();
    test_word_aligned();
    test_back_to_back();
    test_errors();
    test_stall_toggle();
    test_reset_mid_drain();
    test_five_byte();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/keccak_unpadder.md
Name: keccak_unpadder

Overview:
- Receive side of the Keccak byte-padding scheme: takes a stream of 32-bit words forming whole padded rate blocks and recovers the original message.
- The recovered message is emitted in the same word/is_last/byte_num form the padder consumes.
- Buffers one block, locates the 0x06…0x80 pad in the final block, strips it, and emits message words with a last-word byte count.
- Sits at the verification/loopback end of the hash datapath, opposite the padder.

Parameters:
RATE_WORDS, 34, 32-bit words per rate block (34 = 1088-bit rate; 18 = 576-bit).

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
in  in  32  padded block word; byte 0 of the word is in[31:24]
in_valid  in  1  input word valid
in_last  in  1  with in_valid, marks the final word of the final block
in_ready  out  1  block accepts input (FILL state only)
out  out  32  message word; unused bytes forced to 0
out_valid  out  1  output word valid
out_last  out  1  this word ends the message
out_byte_num  out  2  when out_last: valid bytes 0..3 in out (MSB-first); 0 otherwise
out_ready  in  1  downstream accepts word
pad_err  out  1  one-cycle pulse: malformed padding in final block

Behaviour:
- Reset (asynchronous, any state): state=FILL, write/read/scan pointers=0, final flag=0, in_ready=1; out_valid, out_last, out_byte_num, out, pad_err all 0. Buffer contents are don't-care.
- Storage: RATE_WORDS x 32 buffer, single bank; no overlap of fill and drain.
- FILL:
  - in_ready=1. On in_valid, write in to buf[wptr] and increment wptr.
  - If in_last arrives at wptr==RATE_WORDS-1: set final=1, go to SCAN.
  - At wptr==RATE_WORDS-1 with in_last=0: go to DRAIN with end_ptr=RATE_WORDS, no last.
  - If in_last arrives at any other wptr (short block): pulse pad_err, discard the block, stay in FILL with wptr=0.
- SCAN (final block only):
  - Examines one word per cycle, from buf[RATE_WORDS-1] downward.
  - The last byte of the block (buf[RATE_WORDS-1][7:0]) must have bit 7 set, i.e. be 0x80 or 0x86, else error.
  - Walking bytes backward from there, every byte must be 0x00 until the start byte 0x06 is found. 0x86 in the last byte position counts as both start and end.
  - Any other nonzero byte, or running off buf[0] without finding the start, is an error.
  - On error: pulse pad_err, discard the block, go to FILL.
  - On success: msg_len = byte index of the start byte (0..4*RATE_WORDS-1). Go to DRAIN.
  - SCAN takes 1..RATE_WORDS cycles; the exact latency is not contractual.
- DRAIN:
  - out=buf[rptr] with bytes at or beyond msg_len zeroed. out_valid=1.
  - A word is consumed on out_valid&&out_ready. out, out_last and out_byte_num are held stable while out_ready=0.
  - Non-final block: emit all RATE_WORDS words with out_last=0, then go to FILL.
  - Final block: emit words 0..floor(msg_len/4). The last emitted word has out_last=1 and out_byte_num=msg_len%4.
  - If msg_len%4==0, that last word is all-zero with out_byte_num=0, matching padder input convention.
  - After the last word, clear final and go to FILL.
- Ordering: in_ready=0 in SCAN/DRAIN; output order equals input order.
- pad_err is one cycle wide and is never asserted while out_valid=1.

Test Plan (RATE_WORDS=4):
- 5-byte message: words 90ABCDEF, 90060000, 00000000, 00000080 (in_last on 4th) -> out 90ABCDEF last=0; then 90000000 last=1 byte_num=1; pad_err stays 0.
- 15-byte message with 0x86 case: 11111111, 22222222, 33333333, AABBCC86 -> four words out; final is AABBCC00 last=1 byte_num=3.
- Word-aligned message: 12345678, 06000000, 00000000, 00000080 -> 12345678 last=0; then 00000000 last=1 byte_num=0.
- Multi-block: one non-final block A0..A3 (in_last=0) then 06000000, 0, 0, 00000080 -> A0..A3 with last=0; then 00000000 last=1 byte_num=0.
- Errors, each with no output word and in_ready=1 the next cycle:
  - last byte 00 -> one pad_err pulse.
  - stray 01 between 06 and 80 -> one pad_err pulse.
  - in_last on the 2nd word -> one pad_err pulse.
- out_ready toggling 1/0 each cycle during DRAIN keeps out stable while stalled. Asserting reset mid-DRAIN drops out_valid immediately and gives in_ready=1. A fresh block afterwards decodes correctly.
